// File: rtl/gen_reg_file_if.sv
// Bus bundle for the six-entry register bank: one address, one access mode,
// write data in and combinational read data out.
interface gen_reg_file_if;
  logic [1:0]  addr_sel;
  logic [9:0]  addr;
  logic [19:0] data_in;
  logic [19:0] data_out;

  modport master (output addr_sel, output addr, output data_in, input data_out);
  modport slave  (input addr_sel, input addr, input data_in, output data_out);
endinterface

// File: rtl/gen_reg_file.sv
// Six 20-bit registers with full-word and half-word access through one
// shared address/mode; writes on every edge unless mode 11 or out of range.
module gen_reg_file (
  input  logic           clk,
  input  logic           rst,
  gen_reg_file_if.slave  bus
);

  localparam int N_REGS = 6;

  logic [19:0] regs_q [N_REGS];
  logic [19:0] regs_d [N_REGS];
  logic [19:0] rd_data;

  always_comb begin
    for (int i = 0; i < N_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (bus.addr == 10'(i)) begin
        unique case (bus.addr_sel)
          2'b00:   regs_d[i] = bus.data_in;
          2'b01:   regs_d[i] = {bus.data_in[9:0], regs_q[i][9:0]};
          2'b10:   regs_d[i] = {regs_q[i][19:10], bus.data_in[9:0]};
          default: regs_d[i] = regs_q[i];
        endcase
      end
    end
  end

  // Half-word reads are right-justified and zero-extended.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (bus.addr == 10'(i)) begin
        unique case (bus.addr_sel)
          2'b01:   rd_data = {10'b0, regs_q[i][19:10]};
          2'b10:   rd_data = {10'b0, regs_q[i][9:0]};
          default: rd_data = regs_q[i];
        endcase
      end
    end
  end

  assign bus.data_out = rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_gen_reg_file.sv
// Self-checking bench for gen_reg_file: directed vector table, reset corner
// sequences and a randomized run against a behavioural model.
module tb_gen_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gen_reg_file_if bus_if ();

  gen_reg_file dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [9:0]  addr;
    logic [19:0] din;
    logic [19:0] exp;
    string       name;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [19:0] model [6];
  logic [19:0] exp_q [$];
  vec_t vecs [$];

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%05h want=%05h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 6; i++) model[i] = '0;
  endfunction

  function automatic void model_write(input logic [1:0] sel, input logic [9:0] addr,
                                      input logic [19:0] din);
    if (addr < 10'd6) begin
      case (sel)
        2'b00: model[addr] = din;
        2'b01: model[addr][19:10] = din[9:0];
        2'b10: model[addr][9:0] = din[9:0];
        default: ;
      endcase
    end
  endfunction

  function automatic logic [19:0] model_read(input logic [1:0] sel, input logic [9:0] addr);
    logic [19:0] r;
    if (addr >= 10'd6) return '0;
    r = model[addr];
    case (sel)
      2'b01:   return {10'b0, r[19:10]};
      2'b10:   return {10'b0, r[9:0]};
      default: return r;
    endcase
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [9:0] addr, input logic [19:0] din);
    bus_if.addr_sel = sel;
    bus_if.addr     = addr;
    bus_if.data_in  = din;
  endtask

  // Drive at negedge, queue the expected post-edge read, compare after the edge.
  task automatic do_op(input logic [1:0] sel, input logic [9:0] addr,
                       input logic [19:0] din, input logic [19:0] exp, input string name);
    @(negedge clk);
    drive(sel, addr, din);
    exp_q.push_back(exp);
    model_write(sel, addr, din);
    @(posedge clk);
    #1;
    check(name, bus_if.data_out, exp_q.pop_front());
  endtask

  initial begin
    logic [1:0]  s;
    logic [9:0]  a;
    logic [19:0] d;

    vecs.push_back('{2'b00, 10'd0,    20'hAAAAA, 20'hAAAAA, "full_wr_r0"});
    vecs.push_back('{2'b11, 10'd0,    20'h12345, 20'hAAAAA, "ro_mode_r0"});
    vecs.push_back('{2'b01, 10'd1,    20'hCCCCC, 20'h000CC, "hi_wr_r1"});
    vecs.push_back('{2'b11, 10'd1,    20'h00000, 20'h33000, "hi_full_r1"});
    vecs.push_back('{2'b10, 10'd2,    20'hF0F0F, 20'h0030F, "lo_wr_r2"});
    vecs.push_back('{2'b01, 10'd2,    20'h00155, 20'h00155, "hi_wr_r2"});
    vecs.push_back('{2'b11, 10'd2,    20'h00000, 20'h5570F, "full_r2"});
    vecs.push_back('{2'b00, 10'd6,    20'hFFFFF, 20'h00000, "oor_6"});
    vecs.push_back('{2'b00, 10'd1023, 20'hFFFFF, 20'h00000, "oor_1023"});
    vecs.push_back('{2'b11, 10'd0,    20'h00000, 20'hAAAAA, "keep_r0"});
    vecs.push_back('{2'b11, 10'd1,    20'h00000, 20'h33000, "keep_r1"});
    vecs.push_back('{2'b11, 10'd2,    20'h00000, 20'h5570F, "keep_r2"});
    vecs.push_back('{2'b11, 10'd3,    20'h00000, 20'h00000, "keep_r3"});
    vecs.push_back('{2'b11, 10'd4,    20'h00000, 20'h00000, "keep_r4"});
    vecs.push_back('{2'b11, 10'd5,    20'h00000, 20'h00000, "keep_r5"});
    vecs.push_back('{2'b10, 10'd3,    20'h003FF, 20'h003FF, "lo_wr_r3"});
    vecs.push_back('{2'b01, 10'd3,    20'hFFC00, 20'h00000, "hi_ignores_top"});
    vecs.push_back('{2'b11, 10'd3,    20'h00000, 20'h003FF, "full_r3"});

    // Reset held: every register reads zero, even across clock edges.
    model_clear();
    drive(2'b00, 10'd0, 20'hFFFFF);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(2'b11, 10'(i), 20'h0);
      #1;
      check($sformatf("rst_r%0d", i), bus_if.data_out, 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 10'(i), 20'h0);
      #1;
      check($sformatf("post_rst_r%0d", i), bus_if.data_out, 20'h0);
    end

    foreach (vecs[k]) do_op(vecs[k].sel, vecs[k].addr, vecs[k].din, vecs[k].exp, vecs[k].name);

    // Read during write: old value before the edge, new value after.
    @(negedge clk);
    drive(2'b00, 10'd5, 20'h12345);
    #1;
    check("rdw_before", bus_if.data_out, 20'h00000);
    model_write(2'b00, 10'd5, 20'h12345);
    @(posedge clk);
    #1;
    check("rdw_after", bus_if.data_out, 20'h12345);

    // Async reset pulse between edges.
    do_op(2'b00, 10'd3, 20'hAAAAA, 20'hAAAAA, "wr_r3");
    @(negedge clk);
    drive(2'b11, 10'd3, 20'h0);
    #1;
    check("pre_pulse_r3", bus_if.data_out, 20'hAAAAA);
    rst = 1'b1;
    #1;
    check("async_clear_r3", bus_if.data_out, 20'h0);
    rst = 1'b0;
    model_clear();
    do_op(2'b11, 10'd0, 20'h0, 20'h0, "pulse_clear_r0");

    // Reset spanning an edge that carries a write to R4: write is lost.
    @(negedge clk);
    drive(2'b00, 10'd4, 20'h55555);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge_out", bus_if.data_out, 20'h0);
    rst = 1'b0;
    drive(2'b11, 10'd4, 20'h0);
    #1;
    check("rst_edge_r4", bus_if.data_out, 20'h0);
    do_op(2'b00, 10'd4, 20'h55555, 20'h55555, "first_wr_after_rst");

    // Randomized run against the model.
    for (int n = 0; n < 60; n++) begin
      s = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(6, 1023)) : 10'($urandom_range(0, 5));
      d = 20'($urandom);
      model_write(s, a, d);
      @(negedge clk);
      drive(s, a, d);
      exp_q.push_back(model_read(s, a));
      @(posedge clk);
      #1;
      check($sformatf("rand_%0d", n), bus_if.data_out, exp_q.pop_front());
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(2'b11, 10'(i), 20'h0);
      #1;
      check($sformatf("final_r%0d", i), bus_if.data_out, model[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gen_reg_file.md
# gen_reg_file

Six-entry, 20-bit general-purpose register bank for the CPU datapath, with full-word and half-word (10-bit) access. One address and one access-mode select drive a single write port and a single read port. Writes commit on the rising clock edge. The read port is combinational and shows the addressed register through the same access mode.

## Interface
- No parameters. Register count is fixed at 6, word width at 20 bits, half width at 10 bits.
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all six registers.
- `addr_sel` input 2: access mode.
  - 00: full word.
  - 01: high half.
  - 10: low half.
  - 11: read-only full word, no write.
- `addr` input 10: register index; 0–5 valid, 6–1023 out of range.
- `data_in` input 20: write data.
- `data_out` output 20: read data for the addressed register in the current mode.

## Operation
- Storage: `R0`..`R5`, 20 bits each; `R[19:10]` is the high half, `R[9:0]` is the low half.
- Writes occur on every rising `clk` edge when `rst`=0, `addr`<6 and `addr_sel`≠11. There is no separate write enable; mode 11 is the non-destructive read mode.
  - 00: `R[addr]` ← `data_in[19:0]`.
  - 01: `R[addr][19:10]` ← `data_in[9:0]`; the low half is unchanged.
  - 10: `R[addr][9:0]` ← `data_in[9:0]`; the high half is unchanged.
  - 11: no register changes.
- `data_in[19:10]` is ignored in modes 01 and 10.
- `addr` ≥ 6: no write in any mode; `data_out` = 0.
- Read, combinational, addr < 6:
  - 00 or 11: `data_out` = `R[addr]`.
  - 01: `data_out` = {10'b0, `R[addr][19:10]`}.
  - 10: `data_out` = {10'b0, `R[addr][9:0]`}.
- Registers not addressed never change.

## Timing
- Reset:
  - `rst`=1 clears `R0`..`R5` to 0 immediately, without waiting for a clock edge.
  - `data_out` goes to 0 combinationally.
  - Reset is held while `rst`=1 and overrides any write on a coinciding edge.
- Reset mid-operation: a write on the same edge as `rst` assertion is lost. The first write after release occurs on the first rising edge with `rst`=0.
- Write latency: one edge. The new value is visible on `data_out` after the edge, within the same cycle, with no extra pipeline stage.
- Read latency: zero cycles. `data_out` follows `addr`, `addr_sel` and the register contents combinationally.
- Read during write:
  - Before the edge, `data_out` shows the old value.
  - After the edge, it shows the new value.
  - Mode 00/01/10 with a stable `addr` rewrites the register on every edge. This is idempotent if `data_in` is held.
- Out-of-range `addr` or mode 11 on an edge leaves all state untouched.
- Inputs must be stable around the rising `clk` edge (standard setup/hold). No handshake.

## Test plan
- Reset: assert `rst` with `addr`=0..5 in mode 11 -> `data_out`=0x00000 for each; deassert; registers remain 0.
- Full-word write/read:
  - mode 00, `addr`=0, `data_in`=0xAAAAA, one edge -> `data_out`=0xAAAAA.
  - Switch to mode 11, `data_in`=0x12345, one edge -> still 0xAAAAA.
- High-half write/read:
  - mode 01, `addr`=1, `data_in`=0xCCCCC, one edge -> `data_out`=0x000CC.
  - Mode 11 on `addr`=1 -> 0x33000.
- Low-half write/read:
  - mode 10, `addr`=2, `data_in`=0xF0F0F, one edge -> `data_out`=0x0030F.
  - Then mode 01, `addr`=2, `data_in`=0x00155, one edge -> mode 11 read = 0x5570F.
- Out of range: mode 00, `addr`=6 and `addr`=1023, `data_in`=0xFFFFF, edges -> `data_out`=0; mode 11 reads of `R0`..`R5` unchanged.
- Async reset mid-operation:
  - Write 0xAAAAA to `R3`, then pulse `rst` between edges -> `data_out` drops to 0 before the next edge.
  - `rst` asserted on an edge with a mode-00 write to `R4` -> `R4`=0.
